// File: rtl/riscv_icache_line_fill_if.sv
// Narrow single-outstanding memory read bus between the line-fill engine and memory.
// The fill engine is the master: it issues word addresses and receives read data beats.
interface riscv_icache_line_fill_if #(
    parameter int BUS_ADDR  = 25,
    parameter int BUS_WIDTH = 32
);
    logic                 o_riscv_ifill_bus_req;
    logic [BUS_ADDR-1:0]  o_riscv_ifill_bus_addr;
    logic                 i_riscv_ifill_bus_gnt;
    logic                 i_riscv_ifill_bus_rvalid;
    logic [BUS_WIDTH-1:0] i_riscv_ifill_bus_rdata;
    logic                 i_riscv_ifill_bus_err;

    modport master (
        output o_riscv_ifill_bus_req,
        output o_riscv_ifill_bus_addr,
        input  i_riscv_ifill_bus_gnt,
        input  i_riscv_ifill_bus_rvalid,
        input  i_riscv_ifill_bus_rdata,
        input  i_riscv_ifill_bus_err
    );

    modport slave (
        input  o_riscv_ifill_bus_req,
        input  o_riscv_ifill_bus_addr,
        output i_riscv_ifill_bus_gnt,
        output i_riscv_ifill_bus_rvalid,
        output i_riscv_ifill_bus_rdata,
        output i_riscv_ifill_bus_err
    );
endinterface

// File: rtl/riscv_icache_line_fill.sv
// Instruction-cache refill engine: fetches a line as BEATS bus words, assembles it in a
// one-entry line buffer and answers repeated requests for the buffered line without bus traffic.
module riscv_icache_line_fill #(
    parameter int S_ADDR     = 23,
    parameter int LINE_WIDTH = 128,
    parameter int BUS_WIDTH  = 32,
    parameter int BEATS      = LINE_WIDTH / BUS_WIDTH,
    parameter int BUS_ADDR   = S_ADDR + $clog2(BEATS)
) (
    input  logic                  i_riscv_ifill_clk,
    input  logic                  i_riscv_ifill_rst,
    input  logic                  i_riscv_ifill_req,
    input  logic [S_ADDR-1:0]     i_riscv_ifill_line_addr,
    output logic                  o_riscv_ifill_ready,
    output logic [LINE_WIDTH-1:0] o_riscv_ifill_line_data,
    output logic                  o_riscv_ifill_err,
    output logic                  o_riscv_ifill_busy,
    riscv_icache_line_fill_if.master bus
);
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              r_state;
    logic [S_ADDR-1:0]   r_addr;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_buf_valid;
    logic                r_ready;
    logic                r_err;
    logic                r_busy;
    logic                r_bus_req;
    logic [BUS_ADDR-1:0] r_bus_addr;

    logic                w_hit;
    logic                w_beat_ok;
    logic [BEAT_W-1:0]   w_beat_next;

    assign w_hit       = r_buf_valid && (i_riscv_ifill_line_addr == r_addr);
    assign w_beat_ok   = (r_state == WAIT) && bus.i_riscv_ifill_bus_rvalid && !bus.i_riscv_ifill_bus_err;
    // Beat index wraps inside BEAT_W bits so the bus address never carries into the line address.
    assign w_beat_next = r_beat + BEAT_W'(1);

    always_ff @(posedge i_riscv_ifill_clk or negedge i_riscv_ifill_rst) begin
        if (!i_riscv_ifill_rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_beat      <= '0;
            r_buf_valid <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_riscv_ifill_req) begin
                        if (w_hit) begin
                            r_ready <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_addr      <= i_riscv_ifill_line_addr;
                            r_buf_valid <= 1'b0;
                            r_beat      <= '0;
                            r_bus_req   <= 1'b1;
                            r_bus_addr  <= {i_riscv_ifill_line_addr, {BEAT_W{1'b0}}};
                            r_busy      <= 1'b1;
                            r_state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.i_riscv_ifill_bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.i_riscv_ifill_bus_rvalid) begin
                        if (bus.i_riscv_ifill_bus_err) begin
                            // Aborted fill: the buffer stays invalid so the line is re-fetched next time.
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else if (r_beat == LAST_BEAT) begin
                            r_buf_valid <= 1'b1;
                            r_ready     <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            r_beat     <= w_beat_next;
                            r_bus_req  <= 1'b1;
                            r_bus_addr <= {r_addr, w_beat_next};
                            r_state    <= REQ;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_line
            logic [BUS_WIDTH-1:0] r_word;

            always_ff @(posedge i_riscv_ifill_clk or negedge i_riscv_ifill_rst) begin
                if (!i_riscv_ifill_rst) begin
                    r_word <= '0;
                end else if (w_beat_ok && (r_beat == BEAT_W'(gi))) begin
                    r_word <= bus.i_riscv_ifill_bus_rdata;
                end
            end

            assign o_riscv_ifill_line_data[gi*BUS_WIDTH +: BUS_WIDTH] = r_word;
        end
    endgenerate

    assign o_riscv_ifill_ready        = r_ready;
    assign o_riscv_ifill_err          = r_err;
    assign o_riscv_ifill_busy         = r_busy;
    assign bus.o_riscv_ifill_bus_req  = r_bus_req;
    assign bus.o_riscv_ifill_bus_addr = r_bus_addr;
endmodule

// File: doc/riscv_icache_line_fill.md
Name: riscv_icache_line_fill

Overview:
- Refill engine directly upstream of the instruction cache.
- Accepts the cache's line-read request (23-bit line address plus read enable) and fetches the 128-bit line as four 32-bit beats over a narrow single-outstanding memory bus.
- Assembles the beats into a line and returns it with a one-cycle ready pulse.
- Holds a one-entry line buffer, so a repeated request for the just-filled line (e.g. a held read enable or a misaligned second-line fetch) is answered without bus traffic.

Parameters:
S_ADDR, 23, line address width (matches cache memory address output)
LINE_WIDTH, 128, cache line width in bits
BUS_WIDTH, 32, memory bus data width; must divide LINE_WIDTH
BEATS, LINE_WIDTH/BUS_WIDTH (4), beats per line; power of two
BUS_ADDR, S_ADDR+$clog2(BEATS) (25), bus word-address width

Ports:
i_riscv_ifill_clk  in  1  clock
i_riscv_ifill_rst  in  1  reset, asynchronous, active-low
i_riscv_ifill_req  in  1  line read request from cache FSM (level)
i_riscv_ifill_line_addr  in  S_ADDR  requested line address
o_riscv_ifill_ready  out  1  one-cycle pulse: line data valid
o_riscv_ifill_line_data  out  LINE_WIDTH  assembled line
o_riscv_ifill_err  out  1  one-cycle pulse with ready when the fill aborted on bus error
o_riscv_ifill_busy  out  1  high while a bus fill is in progress
o_riscv_ifill_bus_req  out  1  bus read request, held until granted
o_riscv_ifill_bus_addr  out  BUS_ADDR  bus word address {line_addr, beat}
i_riscv_ifill_bus_gnt  in  1  bus accepts address this cycle
i_riscv_ifill_bus_rvalid  in  1  read data valid
i_riscv_ifill_bus_rdata  in  BUS_WIDTH  read data
i_riscv_ifill_bus_err  in  1  error qualifier, sampled with rvalid

Behaviour:
- Clock and reset: one clock, i_riscv_ifill_clk. i_riscv_ifill_rst is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0; line buffer data 0; buffer-valid 0; beat counter 0.
- A reset asserted mid-fill returns the block to IDLE immediately and drops bus_req. Any late rvalid after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, req=1, buffer-valid=1 and line_addr equals the buffered address:
  - Go to DONE; no bus traffic.
  - Ready pulses at T+1, where T is the sampling cycle.
- IDLE, req=1 otherwise:
  - Latch line_addr, clear buffer-valid, set beat=0, go to REQ.
- REQ:
  - bus_req=1 and bus_addr={latched addr, beat}.
  - Stay while gnt=0; address and req are held stable. On gnt=1 go to WAIT.
- WAIT:
  - bus_req=0. On rvalid=1 with err=0, write rdata into bits [BUS_WIDTH*beat +: BUS_WIDTH] (beat 0 = bits 31:0).
  - If beat=BEATS-1: set buffer-valid and go to DONE. Otherwise beat+1 and go to REQ.
- Error: rvalid=1 with err=1 in WAIT aborts the fill.
  - Go to DONE with error flag set; buffer-valid stays 0.
  - The beat being received is not written.
- DONE:
  - ready=1 for exactly one cycle; err=1 in that same cycle if flagged.
  - Return to IDLE.
- Busy is 1 in REQ and WAIT only.
- Miss latency with gnt and rvalid at the earliest opportunity: 2 cycles per beat. Req sampled at T gives ready at T+9.
- line_data always shows the buffer register. It is valid in the ready cycle and stays stable until the next miss fill writes its first beat.
- req dropping mid-fill: the fill still completes and fills the buffer; the ready pulse is still issued.
- req held high across the ready pulse with the same address: buffer hit, ready again at the next-but-one cycle.
- req held high with a new address (misaligned second line): new fill starts.
- Beat counter wraps only within one line. bus_addr never carries into line-address bits.
- gnt or rvalid outside REQ/WAIT respectively: ignored.

Test Plan:
1. Reset low mid-operation, then release; req=1, addr=0x000010; gnt and rvalid immediate; rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> bus_addr 0x40,0x41,0x42,0x43; ready at T+9; line_data=0x44444444_33333333_22222222_11111111; err=0.
2. Repeat req addr=0x000010 after test 1 -> ready at T+1, no bus_req; then addr=0x000011 -> new fill on bus_addr 0x44..0x47.
3. gnt withheld 3 cycles on beat 2 -> bus_req and bus_addr=0x42 held 4 cycles; ready at T+12; data correct.
4. err=1 with rvalid on beat 1 -> ready and err pulse together 1 cycle later; the same address then re-fetches from beat 0 (buffer-valid=0).
5. Reset asserted while in WAIT on beat 2 -> outputs 0 asynchronously; after release, req for the same address performs a full bus fill.
6. req dropped after beat 0 -> remaining beats are fetched; ready pulses; a subsequent same-address req hits the buffer.
